// File: rtl/mem_dbus_ctrl.sv
// Memory-stage data-bus initiator: issues load/store bus requests, stalls the pipe, returns extended load data.
// Optional macro MEM_MISALIGN_EXC_EN: misaligned accesses are rejected without a bus request and flagged on misalign.

module mem_dbus_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    input  logic        hold,
    output logic        dbus_valid,
    output logic [63:0] dbus_addr,
    output logic [1:0]  dbus_size,
    output logic [7:0]  dbus_strobe,
    output logic [63:0] dbus_wdata,
    input  logic        dbus_data_ok,
    input  logic [63:0] dbus_rdata,
    output logic        handshake_stall,
    output logic        data_ok,
    output logic [63:0] rdata,
    output logic        misalign
);

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned LANE_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic               write_q, write_d;
    logic               uns_q, uns_d;

    logic [XLEN-1:0]    sel_addr;
    logic [XLEN-1:0]    sel_wdata;
    logic [SIZE_W-1:0]  sel_size;
    logic               sel_write;
    logic               sel_uns;

    logic [LANE_W-1:0]  lane;
    logic [STRB_W-1:0]  size_mask;
    logic [STRB_W-1:0]  strobe_c;
    logic [XLEN-1:0]    wdata_sh;
    logic [XLEN-1:0]    rdata_sh;
    logic [XLEN-1:0]    load_ext;
    logic [XLEN-1:0]    result_c;
    logic               reject_c;

`ifdef MEM_MISALIGN_EXC_EN
    logic               misalign_q, misalign_d;
`endif

    // While waiting on the bus, the captured request is authoritative; otherwise the live one.
    always_comb begin
        if (state_q == S_BUSY) begin
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
            sel_size  = size_q;
            sel_write = write_q;
            sel_uns   = uns_q;
        end else begin
            sel_addr  = req_addr;
            sel_wdata = req_wdata;
            sel_size  = req_size;
            sel_write = req_write;
            sel_uns   = req_unsigned;
        end
    end

    assign lane = sel_addr[LANE_W-1:0];

    always_comb begin
        size_mask = 8'h01;
        unique case (sel_size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Lanes shifted past byte 7 fall off the top of the 8-bit strobe.
    assign strobe_c = sel_write ? STRB_W'(size_mask << lane) : '0;
    assign wdata_sh = sel_wdata << {lane, 3'b000};
    assign rdata_sh = dbus_rdata >> {lane, 3'b000};

    always_comb begin
        load_ext = rdata_sh;
        unique case (sel_size)
            2'd0:    load_ext = sel_uns ? {56'd0, rdata_sh[7:0]}
                                        : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
            2'd1:    load_ext = sel_uns ? {48'd0, rdata_sh[15:0]}
                                        : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
            2'd2:    load_ext = sel_uns ? {32'd0, rdata_sh[31:0]}
                                        : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
            default: load_ext = rdata_sh;
        endcase
    end

    assign result_c = sel_write ? '0 : load_ext;

`ifdef MEM_MISALIGN_EXC_EN
    always_comb begin
        reject_c = 1'b0;
        unique case (req_size)
            2'd0:    reject_c = 1'b0;
            2'd1:    reject_c = req_addr[0];
            2'd2:    reject_c = |req_addr[1:0];
            default: reject_c = |req_addr[2:0];
        endcase
    end
`else
    assign reject_c = 1'b0;
`endif

    // Next-state, capture and bus-drive logic.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        size_d          = size_q;
        write_d         = write_q;
        uns_d           = uns_q;
        rdata_d         = rdata_q;
`ifdef MEM_MISALIGN_EXC_EN
        misalign_d      = misalign_q;
`endif
        dbus_valid      = 1'b0;
        dbus_addr       = '0;
        dbus_size       = '0;
        dbus_strobe     = '0;
        dbus_wdata      = '0;
        handshake_stall = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    handshake_stall = 1'b1;
                    if (reject_c) begin
                        rdata_d = '0;
                        state_d = S_DONE;
`ifdef MEM_MISALIGN_EXC_EN
                        misalign_d = 1'b1;
`endif
                    end else begin
                        dbus_valid  = 1'b1;
                        dbus_addr   = sel_addr;
                        dbus_size   = sel_size;
                        dbus_strobe = strobe_c;
                        dbus_wdata  = wdata_sh;
                        if (dbus_data_ok) begin
                            rdata_d = result_c;
                            state_d = S_DONE;
                        end else begin
                            addr_d  = req_addr;
                            wdata_d = req_wdata;
                            size_d  = req_size;
                            write_d = req_write;
                            uns_d   = req_unsigned;
                            state_d = S_BUSY;
                        end
                    end
                end
            end
            S_BUSY: begin
                handshake_stall = 1'b1;
                dbus_valid      = 1'b1;
                dbus_addr       = sel_addr;
                dbus_size       = sel_size;
                dbus_strobe     = strobe_c;
                dbus_wdata      = wdata_sh;
                if (dbus_data_ok) begin
                    rdata_d = result_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // The same instruction is still presented here; never re-issue it.
                if (!hold) begin
                    state_d = S_IDLE;
`ifdef MEM_MISALIGN_EXC_EN
                    misalign_d = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            uns_q      <= 1'b0;
            rdata_q    <= '0;
`ifdef MEM_MISALIGN_EXC_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            write_q    <= write_d;
            uns_q      <= uns_d;
            rdata_q    <= rdata_d;
`ifdef MEM_MISALIGN_EXC_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign data_ok = (state_q == S_DONE);
    assign rdata   = rdata_q;

`ifdef MEM_MISALIGN_EXC_EN
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Self-checking bench for mem_dbus_ctrl: byte-level reference model feeding a scoreboard queue.
// Honours MEM_MISALIGN_EXC_EN to pick the matching misalignment scenario.

module tb_mem_dbus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_unsigned, hold;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        dbus_valid;
    logic [63:0] dbus_addr, dbus_wdata;
    logic [1:0]  dbus_size;
    logic [7:0]  dbus_strobe;
    logic        dbus_data_ok;
    logic [63:0] dbus_rdata;
    logic        handshake_stall, data_ok, misalign;
    logic [63:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  strobe;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          stall;
        int          dok;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mem_dbus_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_wdata       (req_wdata),
        .hold            (hold),
        .dbus_valid      (dbus_valid),
        .dbus_addr       (dbus_addr),
        .dbus_size       (dbus_size),
        .dbus_strobe     (dbus_strobe),
        .dbus_wdata      (dbus_wdata),
        .dbus_data_ok    (dbus_data_ok),
        .dbus_rdata      (dbus_rdata),
        .handshake_stall (handshake_stall),
        .data_ok         (data_ok),
        .rdata           (rdata),
        .misalign        (misalign)
    );

    function automatic logic [7:0] model_strobe(input logic w, input int off, input int n);
        logic [7:0] s = '0;
        for (int i = 0; i < 8; i++) s[i] = w && (i >= off) && (i < off + n);
        return s;
    endfunction

    function automatic logic [63:0] model_wdata(input int off, input logic [63:0] wd);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) if (i >= off) r[8*i +: 8] = wd[8*(i-off) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_rdata(input logic w, input int off, input int n,
                                                input logic u, input logic [63:0] bus);
        logic [63:0] r = '0;
        if (w) return '0;
        for (int i = 0; i < 8; i++) if (i < n && off + i < 8) r[8*i +: 8] = bus[8*(off+i) +: 8];
        if (!u && n < 8 && r[8*n-1]) for (int b = 8*n; b < 64; b++) r[b] = 1'b1;
        return r;
    endfunction

    // Drives one transaction (k wait cycles, holdn hold cycles in DONE) and records what the DUT did.
    task automatic drive_txn(input logic w, input logic [63:0] a, input logic [1:0] sz, input logic u,
                             input logic [63:0] wd, input logic [63:0] bus, input int k, input int holdn,
                             output logic o_issue, output logic [7:0] o_strobe, output logic [63:0] o_wdata,
                             output logic [63:0] o_addr, output int o_stall, output int o_unstable,
                             output int o_dok, output logic [63:0] o_rdata, output int o_rchg,
                             output int o_extra, output logic o_dok_after);
        exp_t e;
        int   n;
        n = 1 << sz;
        e.strobe = model_strobe(w, int'(a[2:0]), n);
        e.wdata  = model_wdata(int'(a[2:0]), wd);
        e.rdata  = model_rdata(w, int'(a[2:0]), n, u, bus);
        e.stall  = k + 1;
        e.dok    = holdn + 1;
        sb_q.push_back(e);
        o_stall = 0; o_unstable = 0; o_dok = 0; o_rchg = 0; o_extra = 0; o_rdata = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
        hold = 1'b0; dbus_data_ok = (k == 0); dbus_rdata = (k == 0) ? bus : ~bus;
        #1;
        o_issue = dbus_valid; o_strobe = dbus_strobe; o_wdata = dbus_wdata; o_addr = dbus_addr;
        if (handshake_stall) o_stall++;
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            req_addr = ~a; req_wdata = ~wd; req_size = ~sz; req_unsigned = ~u; hold = 1'b1;
            dbus_data_ok = (i == k); dbus_rdata = (i == k) ? bus : ~bus;
            #1;
            if (handshake_stall) o_stall++;
            if (dbus_valid !== 1'b1 || dbus_addr !== o_addr || dbus_strobe !== o_strobe ||
                dbus_wdata !== o_wdata) o_unstable++;
        end
        for (int j = 0; j <= holdn; j++) begin
            @(negedge clk);
            dbus_data_ok = 1'b0; dbus_rdata = {$urandom, $urandom}; hold = (j < holdn);
            #1;
            if (data_ok === 1'b1) o_dok++;
            if (j == 0) o_rdata = rdata;
            else if (rdata !== o_rdata) o_rchg++;
            if (dbus_valid !== 1'b0) o_extra++;
            if (handshake_stall) o_stall++;
        end
        @(negedge clk);
        req_valid = 1'b0; hold = 1'b0;
        #1;
        o_dok_after = data_ok;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; hold = 1'b0; dbus_data_ok = 1'b0; dbus_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if ({dbus_valid, dbus_strobe, data_ok, misalign, handshake_stall} !== 12'h0) begin
            n_fail++; $display("FAIL reset_ctrl: got v=%b strb=%h dok=%b mis=%b stall=%b required all 0",
                               dbus_valid, dbus_strobe, data_ok, misalign, handshake_stall);
        end
        n_checks++;
        if (dbus_addr !== 64'h0 || dbus_wdata !== 64'h0 || rdata !== 64'h0) begin
            n_fail++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h required 0",
                               dbus_addr, dbus_wdata, rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_signed_byte_load();
        logic iss, dok_after; logic [7:0] st; logic [63:0] wd, ad, rd; int stl, uns, dok, rchg, ext;
        exp_t e;
        drive_txn(1'b0, 64'h1003, 2'd0, 1'b0, 64'h0, 64'h00000000_80FF0000, 2, 0,
                  iss, st, wd, ad, stl, uns, dok, rd, rchg, ext, dok_after);
        e = sb_q.pop_front();
        n_checks++;
        if (iss !== 1'b1 || ad !== 64'h1003) begin
            n_fail++; $display("FAIL sbl_issue: got valid=%b addr=%h required 1/1003", iss, ad);
        end
        n_checks++;
        if (st !== e.strobe || st !== 8'h00) begin
            n_fail++; $display("FAIL sbl_strobe: got %h required 00", st);
        end
        n_checks++;
        if (stl !== e.stall || stl !== 3 || uns !== 0) begin
            n_fail++; $display("FAIL sbl_stall: got %0d cycles (unstable %0d) required 3", stl, uns);
        end
        n_checks++;
        if (rd !== e.rdata || rd !== 64'hFFFFFFFF_FFFFFF80) begin
            n_fail++; $display("FAIL sbl_rdata: got %h required ffffffffffffff80", rd);
        end
        n_checks++;
        if (dok !== e.dok || dok_after !== 1'b0) begin
            n_fail++; $display("FAIL sbl_data_ok: got %0d cycles after=%b required 1/0", dok, dok_after);
        end
    endtask

    task automatic test_zero_wait_store();
        logic iss, dok_after; logic [7:0] st; logic [63:0] wd, ad, rd; int stl, uns, dok, rchg, ext;
        exp_t e;
        drive_txn(1'b1, 64'h2004, 2'd2, 1'b0, 64'hDEADBEEF, 64'h0, 0, 0,
                  iss, st, wd, ad, stl, uns, dok, rd, rchg, ext, dok_after);
        e = sb_q.pop_front();
        n_checks++;
        if (st !== e.strobe || st !== 8'hF0) begin
            n_fail++; $display("FAIL zws_strobe: got %h required f0", st);
        end
        n_checks++;
        if (wd !== e.wdata || wd !== 64'hDEADBEEF_00000000) begin
            n_fail++; $display("FAIL zws_wdata: got %h required deadbeef00000000", wd);
        end
        n_checks++;
        if (stl !== e.stall || stl !== 1) begin
            n_fail++; $display("FAIL zws_stall: got %0d required 1", stl);
        end
        n_checks++;
        if (dok !== 1 || rd !== e.rdata || rd !== 64'h0) begin
            n_fail++; $display("FAIL zws_done: got dok=%0d rdata=%h required 1/0", dok, rd);
        end
    endtask

    task automatic test_hold_done();
        logic iss, dok_after; logic [7:0] st; logic [63:0] wd, ad, rd; int stl, uns, dok, rchg, ext;
        exp_t e;
        drive_txn(1'b0, 64'h6, 2'd1, 1'b1, 64'h0, 64'hABCD_0000_0000_0000, 1, 3,
                  iss, st, wd, ad, stl, uns, dok, rd, rchg, ext, dok_after);
        e = sb_q.pop_front();
        n_checks++;
        if (rd !== e.rdata || rd !== 64'hABCD || rchg !== 0) begin
            n_fail++; $display("FAIL hold_rdata: got %h (changes %0d) required abcd stable", rd, rchg);
        end
        n_checks++;
        if (dok !== e.dok || dok !== 4 || dok_after !== 1'b0) begin
            n_fail++; $display("FAIL hold_data_ok: got %0d cycles after=%b required 4/0", dok, dok_after);
        end
        n_checks++;
        if (ext !== 0 || stl !== e.stall) begin
            n_fail++; $display("FAIL hold_no_reissue: got valid_in_done=%0d stall=%0d required 0/%0d",
                               ext, stl, e.stall);
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h40; req_size = 2'd3; req_unsigned = 1'b0;
        dbus_data_ok = 1'b0; hold = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (dbus_valid !== 1'b1 || handshake_stall !== 1'b1) begin
            n_fail++; $display("FAIL rstb_busy: got valid=%b stall=%b required 1/1", dbus_valid, handshake_stall);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        #1;
        n_checks++;
        if (dbus_valid !== 1'b0 || data_ok !== 1'b0 || rdata !== 64'h0) begin
            n_fail++; $display("FAIL rstb_after: got valid=%b dok=%b rdata=%h required 0/0/0",
                               dbus_valid, data_ok, rdata);
        end
        @(negedge clk);
        dbus_data_ok = 1'b1; dbus_rdata = 64'h1234;
        @(negedge clk);
        dbus_data_ok = 1'b0;
        #1;
        n_checks++;
        if (data_ok !== 1'b0 || handshake_stall !== 1'b0 || dbus_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstb_late_ok: got dok=%b stall=%b valid=%b required 0/0/0",
                               data_ok, handshake_stall, dbus_valid);
        end
    endtask

`ifdef MEM_MISALIGN_EXC_EN
    task automatic test_misalign();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h3002; req_size = 2'd2; req_unsigned = 1'b0;
        dbus_data_ok = 1'b0; hold = 1'b0;
        #1;
        n_checks++;
        if (dbus_valid !== 1'b0 || handshake_stall !== 1'b1) begin
            n_fail++; $display("FAIL mis_issue: got valid=%b stall=%b required 0/1", dbus_valid, handshake_stall);
        end
        @(negedge clk); #1;
        n_checks++;
        if (misalign !== 1'b1 || data_ok !== 1'b1 || dbus_valid !== 1'b0 || handshake_stall !== 1'b0) begin
            n_fail++; $display("FAIL mis_done: got mis=%b dok=%b valid=%b stall=%b required 1/1/0/0",
                               misalign, data_ok, dbus_valid, handshake_stall);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n_checks++;
        if (misalign !== 1'b0 || data_ok !== 1'b0) begin
            n_fail++; $display("FAIL mis_clear: got mis=%b dok=%b required 0/0", misalign, data_ok);
        end
    endtask
`else
    task automatic test_misalign();
        logic iss, dok_after; logic [7:0] st; logic [63:0] wd, ad, rd; int stl, uns, dok, rchg, ext;
        exp_t e;
        drive_txn(1'b1, 64'h3002, 2'd2, 1'b0, 64'h11223344, 64'h0, 1, 0,
                  iss, st, wd, ad, stl, uns, dok, rd, rchg, ext, dok_after);
        e = sb_q.pop_front();
        n_checks++;
        if (iss !== 1'b1 || st !== e.strobe || st !== 8'h3C || misalign !== 1'b0) begin
            n_fail++; $display("FAIL mis_issue: got valid=%b strobe=%h mis=%b required 1/3c/0", iss, st, misalign);
        end
        n_checks++;
        if (wd !== e.wdata || stl !== e.stall) begin
            n_fail++; $display("FAIL mis_wdata: got %h stall=%0d required %h stall=%0d", wd, stl, e.wdata, e.stall);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic iss, dok_after; logic [7:0] st; logic [63:0] wd, ad, rd; int stl, uns, dok, rchg, ext;
        exp_t e;
        logic [1:0] sz; logic [63:0] a;
        for (int t = 0; t < 24; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom} & ~64'(((1 << sz) - 1));
            drive_txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                      {$urandom, $urandom} | 64'h8080_8080_8080_8080 & {$urandom, $urandom},
                      $urandom_range(0, 3), $urandom_range(0, 2),
                      iss, st, wd, ad, stl, uns, dok, rd, rchg, ext, dok_after);
            e = sb_q.pop_front();
            n_checks++;
            if (iss !== 1'b1 || ad !== a || st !== e.strobe || wd !== e.wdata || uns !== 0) begin
                n_fail++; $display("FAIL b2b_bus[%0d]: got strobe=%h wdata=%h addr=%h unstable=%0d required %h/%h/%h",
                                   t, st, wd, ad, uns, e.strobe, e.wdata, a);
            end
            n_checks++;
            if (rd !== e.rdata || rchg !== 0) begin
                n_fail++; $display("FAIL b2b_rdata[%0d]: got %h required %h", t, rd, e.rdata);
            end
            n_checks++;
            if (stl !== e.stall || dok !== e.dok || ext !== 0 || dok_after !== 1'b0) begin
                n_fail++; $display("FAIL b2b_timing[%0d]: got stall=%0d dok=%0d required %0d/%0d",
                                   t, stl, dok, e.stall, e.dok);
            end
        end
        n_checks++;
        if (sb_q.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left required 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_signed_byte_load();
        test_zero_wait_store();
        test_hold_done();
        test_reset_busy();
        test_misalign();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
